// File: rtl/rtype_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the R-type datapath.
// Optional retire counter port enabled by defining SEQ_RETIRE_CNT_EN.
module rtype_seq_ctrl #(
    parameter int FETCH_TIMEOUT = 16,
    parameter int XLEN          = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run_en,
    output logic            imem_req,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] ir,
    output logic            pc_en,
    output logic            rf_we,
    output logic [1:0]      aluop,
    output logic            busy,
    output logic            trap,
    output logic [1:0]      trap_cause
`ifdef SEQ_RETIRE_CNT_EN
    ,
    output logic [31:0]     retire_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    localparam logic [1:0] ALUOP_RTYPE   = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [7:0] CNT_LAST      = 8'(FETCH_TIMEOUT - 1);

    state_t     state_r;
    logic [7:0] fetch_cnt_r;

    // Only base add/sub/shift/logic R-type encodings are accepted; bit 30 is legal for sub and sra only.
    function automatic logic is_legal_rtype(input logic [6:0] opcode,
                                            input logic [6:0] funct7,
                                            input logic [2:0] funct3);
        logic legal;
        legal = 1'b0;
        if (opcode == 7'b0110011) begin
            case (funct7)
                7'b0000000: legal = 1'b1;
                7'b0100000: legal = (funct3 == 3'b000) || (funct3 == 3'b101);
                default:    legal = 1'b0;
            endcase
        end else begin
            legal = 1'b0;
        end
        return legal;
    endfunction

    // Sequencer: state plus every output registered together, so outputs track the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            fetch_cnt_r <= 8'd0;
            ir          <= '0;
            imem_req    <= 1'b0;
            pc_en       <= 1'b0;
            rf_we       <= 1'b0;
            aluop       <= 2'b00;
            busy        <= 1'b0;
            trap        <= 1'b0;
            trap_cause  <= 2'b00;
        end else begin
            imem_req <= 1'b0;
            pc_en    <= 1'b0;
            rf_we    <= 1'b0;
            aluop    <= 2'b00;
            case (state_r)
                S_IDLE: begin
                    if (run_en) begin
                        state_r  <= S_FETCH;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        state_r  <= S_IDLE;
                        busy     <= 1'b0;
                    end
                end
                S_FETCH: begin
                    // A ready arriving on the last allowed cycle still completes the fetch.
                    if (imem_ready) begin
                        ir          <= imem_rdata;
                        fetch_cnt_r <= 8'd0;
                        state_r     <= S_DECODE;
                    end else if (fetch_cnt_r == CNT_LAST) begin
                        fetch_cnt_r <= 8'd0;
                        state_r     <= S_TRAP;
                        busy        <= 1'b0;
                        trap        <= 1'b1;
                        trap_cause  <= CAUSE_TIMEOUT;
                    end else begin
                        fetch_cnt_r <= fetch_cnt_r + 8'd1;
                        imem_req    <= 1'b1;
                        state_r     <= S_FETCH;
                    end
                end
                S_DECODE: begin
                    if (is_legal_rtype(ir[6:0], ir[31:25], ir[14:12])) begin
                        state_r <= S_EXECUTE;
                        aluop   <= ALUOP_RTYPE;
                    end else begin
                        state_r    <= S_TRAP;
                        busy       <= 1'b0;
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_ILLEGAL;
                    end
                end
                S_EXECUTE: begin
                    state_r <= S_WRITEBACK;
                    aluop   <= ALUOP_RTYPE;
                    pc_en   <= 1'b1;
                    rf_we   <= (ir[11:7] != 5'd0);
                end
                S_WRITEBACK: begin
                    if (run_en) begin
                        state_r  <= S_FETCH;
                        imem_req <= 1'b1;
                    end else begin
                        state_r  <= S_IDLE;
                        busy     <= 1'b0;
                    end
                end
                S_TRAP: begin
                    state_r <= S_TRAP;
                    busy    <= 1'b0;
                    trap    <= 1'b1;
                end
                default: begin
                    state_r     <= S_IDLE;
                    fetch_cnt_r <= 8'd0;
                    busy        <= 1'b0;
                    trap        <= 1'b0;
                    trap_cause  <= 2'b00;
                end
            endcase
        end
    end

`ifdef SEQ_RETIRE_CNT_EN
    // Retired-instruction counter, one count per pc_en pulse, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt <= 32'd0;
        end else if (pc_en) begin
            retire_cnt <= retire_cnt + 32'd1;
        end else begin
            retire_cnt <= retire_cnt;
        end
    end
`endif

endmodule
